// File: rtl/nvdla_cvif_csb_adapter_if.sv
// CSB request/response channel between the CSB master and the CVIF register adapter.
interface nvdla_cvif_csb_adapter_if;
  logic        csb2cvif_req_pvld;
  logic        csb2cvif_req_prdy;
  logic [62:0] csb2cvif_req_pd;
  logic        cvif2csb_resp_valid;
  logic        cvif2csb_resp_ready;
  logic [33:0] cvif2csb_resp_pd;

  modport master (
    output csb2cvif_req_pvld, csb2cvif_req_pd, cvif2csb_resp_ready,
    input  csb2cvif_req_prdy, cvif2csb_resp_valid, cvif2csb_resp_pd
  );

  modport slave (
    input  csb2cvif_req_pvld, csb2cvif_req_pd, cvif2csb_resp_ready,
    output csb2cvif_req_prdy, cvif2csb_resp_valid, cvif2csb_resp_pd
  );
endinterface

// File: rtl/nvdla_cvif_csb_adapter.sv
// CSB-to-flat-register adapter for the CVIF window; optional byte-enable
// read-modify-write writes are enabled by defining NVDLA_CVIF_CSB_WRBE_EN.
module nvdla_cvif_csb_adapter #(
  parameter logic [11:0] BLK_ADDR_HI   = 12'h003,
  parameter logic [11:0] BLK_ADDR_MASK = 12'hfff
) (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rstn,
  nvdla_cvif_csb_adapter_if.slave         csb,
  output logic [11:0]                     reg_offset,
  output logic [31:0]                     reg_wr_data,
  output logic                            reg_wr_en,
  input  logic [31:0]                     reg_rd_data
);

`ifdef NVDLA_CVIF_CSB_WRBE_EN
  typedef enum logic [1:0] {IDLE, EXEC, RESP, MERGE} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

  state_t      state, state_nxt;
  logic        cap_write, cap_write_nxt;
  logic        cap_nposted, cap_nposted_nxt;
  logic        cap_hit, cap_hit_nxt;
  logic [3:0]  cap_wrbe, cap_wrbe_nxt;
  logic [11:0] offset_nxt;
  logic [31:0] wr_data_nxt;
  logic        wr_en_nxt;
  logic        resp_valid, resp_valid_nxt;
  logic [33:0] resp_pd, resp_pd_nxt;

  logic [21:0] req_addr;
  logic [31:0] req_wdat;
  logic        req_write;
  logic        req_nposted;
  logic [3:0]  req_wrbe;
  logic        req_hit;
  logic        accept;

  assign req_addr    = csb.csb2cvif_req_pd[21:0];
  assign req_wdat    = csb.csb2cvif_req_pd[53:22];
  assign req_write   = csb.csb2cvif_req_pd[54];
  assign req_nposted = csb.csb2cvif_req_pd[55];
  assign req_wrbe    = csb.csb2cvif_req_pd[60:57];
  assign req_hit     = ((req_addr[21:10] & BLK_ADDR_MASK) == (BLK_ADDR_HI & BLK_ADDR_MASK));

  assign csb.csb2cvif_req_prdy   = (state == IDLE);
  assign csb.cvif2csb_resp_valid = resp_valid;
  assign csb.cvif2csb_resp_pd    = resp_pd;
  assign accept                  = csb.csb2cvif_req_pvld & (state == IDLE);

`ifdef NVDLA_CVIF_CSB_WRBE_EN
  logic [31:0] merged;
  logic        unused_req_bits;
  assign unused_req_bits = ^{csb.csb2cvif_req_pd[62:61], csb.csb2cvif_req_pd[56]};

  // reg_wr_data still holds the request's wdat while in EXEC, so it supplies the new bytes.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      merged[8*i +: 8] = cap_wrbe[i] ? reg_wr_data[8*i +: 8] : reg_rd_data[8*i +: 8];
    end
  end
`else
  logic unused_req_bits;
  assign unused_req_bits = ^{csb.csb2cvif_req_pd[62:61], csb.csb2cvif_req_pd[56], cap_wrbe};
`endif

  always_comb begin
    state_nxt       = state;
    cap_write_nxt   = cap_write;
    cap_nposted_nxt = cap_nposted;
    cap_hit_nxt     = cap_hit;
    cap_wrbe_nxt    = cap_wrbe;
    offset_nxt      = reg_offset;
    wr_data_nxt     = reg_wr_data;
    wr_en_nxt       = 1'b0;
    resp_valid_nxt  = resp_valid;
    resp_pd_nxt     = resp_pd;

    case (state)
      IDLE: begin
        if (accept) begin
          cap_write_nxt   = req_write;
          cap_nposted_nxt = req_nposted;
          cap_hit_nxt     = req_hit;
          cap_wrbe_nxt    = req_wrbe;
          offset_nxt      = {req_addr[9:0], 2'b00};
          wr_data_nxt     = req_wdat;
`ifdef NVDLA_CVIF_CSB_WRBE_EN
          wr_en_nxt       = req_write & req_hit & (req_wrbe == 4'hf);
`else
          wr_en_nxt       = req_write & req_hit;
`endif
          state_nxt       = EXEC;
        end
      end
      EXEC: begin
        if (!cap_write) begin
          resp_pd_nxt    = {1'b0, ~cap_hit, cap_hit ? reg_rd_data : 32'h0};
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
        end
`ifdef NVDLA_CVIF_CSB_WRBE_EN
        else if (cap_hit && (cap_wrbe != 4'hf)) begin
          wr_data_nxt = merged;
          wr_en_nxt   = |cap_wrbe;
          state_nxt   = MERGE;
        end
`endif
        else if (cap_nposted) begin
          resp_pd_nxt    = {1'b1, ~cap_hit, 32'h0};
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
        end else begin
          state_nxt = IDLE;
        end
      end
`ifdef NVDLA_CVIF_CSB_WRBE_EN
      MERGE: begin
        if (cap_nposted) begin
          resp_pd_nxt    = {1'b1, 1'b0, 32'h0};
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      RESP: begin
        if (csb.cvif2csb_resp_ready) begin
          resp_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state       <= IDLE;
      cap_write   <= 1'b0;
      cap_nposted <= 1'b0;
      cap_hit     <= 1'b0;
      cap_wrbe    <= '0;
      reg_offset  <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_pd     <= '0;
    end else begin
      state       <= state_nxt;
      cap_write   <= cap_write_nxt;
      cap_nposted <= cap_nposted_nxt;
      cap_hit     <= cap_hit_nxt;
      cap_wrbe    <= cap_wrbe_nxt;
      reg_offset  <= offset_nxt;
      reg_wr_data <= wr_data_nxt;
      reg_wr_en   <= wr_en_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_pd     <= resp_pd_nxt;
    end
  end

endmodule

// File: tb/tb_nvdla_cvif_csb_adapter.sv
// Directed bench for nvdla_cvif_csb_adapter; expectations are hand-computed per scenario.
module tb_nvdla_cvif_csb_adapter;
  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  int          vectors = 0;
  int          errors  = 0;

  nvdla_cvif_csb_adapter_if csb_if();

  nvdla_cvif_csb_adapter #(
    .BLK_ADDR_HI   (12'h003),
    .BLK_ADDR_MASK (12'hfff)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .csb             (csb_if.slave),
    .reg_offset      (reg_offset),
    .reg_wr_data     (reg_wr_data),
    .reg_wr_en       (reg_wr_en),
    .reg_rd_data     (reg_rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [21:0] addr, input logic [31:0] wdat,
                           input logic write, input logic nposted, input logic [3:0] wrbe);
    csb_if.csb2cvif_req_pd   = {2'b00, wrbe, 1'b0, nposted, write, wdat, addr};
    csb_if.csb2cvif_req_pvld = 1'b1;
  endtask

  // Drive a request while prdy is high and let the next edge accept it.
  task automatic accept_req(input logic [21:0] addr, input logic [31:0] wdat,
                            input logic write, input logic nposted, input logic [3:0] wrbe);
    drive_req(addr, wdat, write, nposted, wrbe);
    step();
    csb_if.csb2cvif_req_pvld = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    csb_if.csb2cvif_req_pvld   = 1'b0;
    csb_if.csb2cvif_req_pd     = '0;
    csb_if.cvif2csb_resp_ready = 1'b1;
    reg_rd_data = 32'h0;
    #12;
    vectors++; if (csb_if.csb2cvif_req_prdy !== 1'b1) begin errors++; $display("FAIL rst_prdy: got %b want 1", csb_if.csb2cvif_req_prdy); end
    vectors++; if (csb_if.cvif2csb_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", csb_if.cvif2csb_resp_valid); end
    vectors++; if (csb_if.cvif2csb_resp_pd !== 34'h0) begin errors++; $display("FAIL rst_pd: got %h want 0", csb_if.cvif2csb_resp_pd); end
    vectors++; if ({reg_offset, reg_wr_data, reg_wr_en} !== 45'h0) begin errors++; $display("FAIL rst_reg: got %h/%h/%b want 0/0/0", reg_offset, reg_wr_data, reg_wr_en); end
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_read();
    reg_rd_data = 32'h0000ffff;
    accept_req(22'h000c05, 32'h0, 1'b0, 1'b0, 4'hf);
    vectors++; if (reg_offset !== 12'h014) begin errors++; $display("FAIL rd_offset: got %h want 014", reg_offset); end
    vectors++; if (csb_if.csb2cvif_req_prdy !== 1'b0) begin errors++; $display("FAIL rd_prdy_exec: got %b want 0", csb_if.csb2cvif_req_prdy); end
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rd_wr_en: got %b want 0", reg_wr_en); end
    step();
    vectors++; if (csb_if.cvif2csb_resp_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b want 1", csb_if.cvif2csb_resp_valid); end
    vectors++; if (csb_if.cvif2csb_resp_pd !== 34'h0_0000ffff) begin errors++; $display("FAIL rd_pd: got %h want 00000ffff", csb_if.cvif2csb_resp_pd); end
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL rd_wr_en2: got %b want 0", reg_wr_en); end
    step();
    vectors++; if (csb_if.cvif2csb_resp_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b want 0", csb_if.cvif2csb_resp_valid); end
    vectors++; if (csb_if.csb2cvif_req_prdy !== 1'b1) begin errors++; $display("FAIL rd_prdy_idle: got %b want 1", csb_if.csb2cvif_req_prdy); end
  endtask

  task automatic test_posted_write();
    accept_req(22'h000c00, 32'h04030201, 1'b1, 1'b0, 4'hf);
    vectors++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL pw_wr_en: got %b want 1", reg_wr_en); end
    vectors++; if (reg_offset !== 12'h000) begin errors++; $display("FAIL pw_offset: got %h want 000", reg_offset); end
    vectors++; if (reg_wr_data !== 32'h04030201) begin errors++; $display("FAIL pw_data: got %h want 04030201", reg_wr_data); end
    step();
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL pw_wr_en_clr: got %b want 0", reg_wr_en); end
    vectors++; if (csb_if.cvif2csb_resp_valid !== 1'b0) begin errors++; $display("FAIL pw_no_resp: got %b want 0", csb_if.cvif2csb_resp_valid); end
    vectors++; if (csb_if.csb2cvif_req_prdy !== 1'b1) begin errors++; $display("FAIL pw_prdy: got %b want 1", csb_if.csb2cvif_req_prdy); end
  endtask

  task automatic test_back_to_back();
    accept_req(22'h000c10, 32'h11111111, 1'b1, 1'b0, 4'hf);
    vectors++; if (reg_wr_en !== 1'b1) begin errors++; $display("FAIL b2b_en_a: got %b want 1", reg_wr_en); end
    step();
    accept_req(22'h000c11, 32'h22222222, 1'b1, 1'b0, 4'hf);
    vectors++; if ({reg_wr_en, reg_offset, reg_wr_data} !== {1'b1, 12'h044, 32'h22222222}) begin errors++; $display("FAIL b2b_b: got %b/%h/%h want 1/044/22222222", reg_wr_en, reg_offset, reg_wr_data); end
    step();
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL b2b_en_clr: got %b want 0", reg_wr_en); end
  endtask

  task automatic test_nposted_write();
    accept_req(22'h000c03, 32'hdeadbeef, 1'b1, 1'b1, 4'hf);
    vectors++; if ({reg_wr_en, reg_offset} !== {1'b1, 12'h00c}) begin errors++; $display("FAIL npw_strobe: got %b/%h want 1/00c", reg_wr_en, reg_offset); end
    step();
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL npw_wr_en_clr: got %b want 0", reg_wr_en); end
    vectors++; if (csb_if.cvif2csb_resp_valid !== 1'b1) begin errors++; $display("FAIL npw_valid: got %b want 1", csb_if.cvif2csb_resp_valid); end
    vectors++; if (csb_if.cvif2csb_resp_pd !== 34'h2_0000_0000) begin errors++; $display("FAIL npw_pd: got %h want 200000000", csb_if.cvif2csb_resp_pd); end
    step();
  endtask

  task automatic test_miss();
    reg_rd_data = 32'h0000ffff;
    accept_req(22'h000400, 32'h0, 1'b0, 1'b0, 4'hf);
    step();
    vectors++; if (csb_if.cvif2csb_resp_pd !== 34'h1_0000_0000) begin errors++; $display("FAIL miss_rd_pd: got %h want 100000000", csb_if.cvif2csb_resp_pd); end
    step();
    accept_req(22'h000400, 32'hcafef00d, 1'b1, 1'b1, 4'hf);
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL miss_wr_en: got %b want 0", reg_wr_en); end
    step();
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL miss_wr_en2: got %b want 0", reg_wr_en); end
    vectors++; if ({csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd} !== {1'b1, 34'h3_0000_0000}) begin errors++; $display("FAIL miss_wr_pd: got %b/%h want 1/300000000", csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd); end
    step();
  endtask

  task automatic test_backpressure();
    csb_if.cvif2csb_resp_ready = 1'b0;
    reg_rd_data = 32'h0000ffff;
    accept_req(22'h000c05, 32'h0, 1'b0, 1'b0, 4'hf);
    step();
    reg_rd_data = 32'h12345678;
    drive_req(22'h000c07, 32'h0, 1'b0, 1'b0, 4'hf);
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd, csb_if.csb2cvif_req_prdy} !== {1'b1, 34'h0_0000ffff, 1'b0}) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%b want 1/00000ffff/0", i, csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd, csb_if.csb2cvif_req_prdy); end
      step();
    end
    csb_if.cvif2csb_resp_ready = 1'b1;
    step();
    vectors++; if ({csb_if.cvif2csb_resp_valid, csb_if.csb2cvif_req_prdy} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b%b want 01", csb_if.cvif2csb_resp_valid, csb_if.csb2cvif_req_prdy); end
    vectors++; if (reg_offset !== 12'h014) begin errors++; $display("FAIL bp_held_not_taken: got %h want 014", reg_offset); end
    step();
    csb_if.csb2cvif_req_pvld = 1'b0;
    vectors++; if ({reg_offset, csb_if.csb2cvif_req_prdy} !== {12'h01c, 1'b0}) begin errors++; $display("FAIL bp_next_accept: got %h/%b want 01c/0", reg_offset, csb_if.csb2cvif_req_prdy); end
    step();
    vectors++; if (csb_if.cvif2csb_resp_pd !== 34'h0_12345678) begin errors++; $display("FAIL bp_next_pd: got %h want 012345678", csb_if.cvif2csb_resp_pd); end
    step();
  endtask

  task automatic test_reset_mid();
    csb_if.cvif2csb_resp_ready = 1'b0;
    accept_req(22'h000c02, 32'h0, 1'b0, 1'b0, 4'hf);
    step();
    vectors++; if (csb_if.cvif2csb_resp_valid !== 1'b1) begin errors++; $display("FAIL rm_valid_pre: got %b want 1", csb_if.cvif2csb_resp_valid); end
    rstn = 1'b0;
    #1;
    vectors++; if ({csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd, csb_if.csb2cvif_req_prdy, reg_offset} !== {1'b0, 34'h0, 1'b1, 12'h000}) begin errors++; $display("FAIL rm_async: got %b/%h/%b/%h want 0/0/1/000", csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd, csb_if.csb2cvif_req_prdy, reg_offset); end
    #1;
    csb_if.cvif2csb_resp_ready = 1'b1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({csb_if.cvif2csb_resp_valid, reg_wr_en, csb_if.csb2cvif_req_prdy} !== 3'b001) begin errors++; $display("FAIL rm_after[%0d]: got %b%b%b want 001", i, csb_if.cvif2csb_resp_valid, reg_wr_en, csb_if.csb2cvif_req_prdy); end
    end
  endtask

`ifdef NVDLA_CVIF_CSB_WRBE_EN
  task automatic test_wrbe();
    reg_rd_data = 32'h11223344;
    accept_req(22'h000c01, 32'haabbccdd, 1'b1, 1'b1, 4'b0010);
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL wrbe_t1: got %b want 0", reg_wr_en); end
    step();
    vectors++; if ({reg_wr_en, reg_wr_data, reg_offset} !== {1'b1, 32'h1122cc44, 12'h004}) begin errors++; $display("FAIL wrbe_merge: got %b/%h/%h want 1/1122cc44/004", reg_wr_en, reg_wr_data, reg_offset); end
    step();
    vectors++; if ({reg_wr_en, csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd} !== {2'b01, 34'h2_0000_0000}) begin errors++; $display("FAIL wrbe_resp: got %b%b/%h want 01/200000000", reg_wr_en, csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd); end
    step();
    accept_req(22'h000c01, 32'haabbccdd, 1'b1, 1'b1, 4'h0);
    step();
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL wrbe0_no_strobe: got %b want 0", reg_wr_en); end
    step();
    vectors++; if ({csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd} !== {1'b1, 34'h2_0000_0000}) begin errors++; $display("FAIL wrbe0_ack: got %b/%h want 1/200000000", csb_if.cvif2csb_resp_valid, csb_if.cvif2csb_resp_pd); end
    step();
  endtask
`else
  task automatic test_wrbe();
    reg_rd_data = 32'h11223344;
    accept_req(22'h000c01, 32'haabbccdd, 1'b1, 1'b0, 4'b0010);
    vectors++; if ({reg_wr_en, reg_wr_data} !== {1'b1, 32'haabbccdd}) begin errors++; $display("FAIL wrbe_ignored: got %b/%h want 1/aabbccdd", reg_wr_en, reg_wr_data); end
    step();
    vectors++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL wrbe_ignored_clr: got %b want 0", reg_wr_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_posted_write();
    test_back_to_back();
    test_nposted_write();
    test_miss();
    test_backpressure();
    test_wrbe();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
